instr_fetch: RTL and testbench

- Instruction fetch stage directly upstream of the decoder.
- Generates sequential PCs and issues word requests to instruction memory.
- Buffers in-order responses together with their PC in a small FIFO.
- Presents {instr, instr_pc} to decode over a valid/ready handshake; a redirect from execute (branch, jump, trap) flushes the buffer and discards stale responses.

---
 rtl/instr_fetch.sv | 162 ++++++++++++++++
 tb/tb_instr_fetch.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: sequential PC generation, credit-limited word requests to
// instruction memory, and buffering of in-order responses (tagged with their
// PC) for the decoder. A redirect flushes the buffer, restarts fetch at the
// new PC, and marks every outstanding response as stale so it gets dropped.
// Latency: response to instr_valid is 1 cycle. Backpressure: instr_ready low
// fills the FIFO, which closes the credit window and stops new requests.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   imem_req_valid/addr/ready         fetch request channel (word aligned)
//   imem_rsp_valid/data               in-order response channel (no ready)
//   redirect_valid/pc                 flush and restart fetch at redirect_pc
//   instr_valid/instr/instr_pc/ready  valid/ready channel to decode
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  // Wide enough to hold count + inflight + drop_cnt without overflow.
  localparam int SW = CW + 2;
  localparam logic [SW-1:0] DEPTH_W = SW'(DEPTH);
  localparam logic [31:0] RESET_PC_W = {RESET_PC[31:2], 2'b00};

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
  } fetch_entry_t;

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;

  // Pending-address queue: PCs of requests whose responses are still owed.
  logic [31:0]   pa_mem_q [DEPTH];
  logic [31:0]   pa_mem_d [DEPTH];
  logic [AW-1:0] pa_wr_q, pa_wr_d;
  logic [AW-1:0] pa_rd_q, pa_rd_d;

  // Instruction FIFO presented to decode.
  fetch_entry_t  if_mem_q [DEPTH];
  fetch_entry_t  if_mem_d [DEPTH];
  logic [AW-1:0] if_wr_q, if_wr_d;
  logic [AW-1:0] if_rd_q, if_rd_d;

  logic [SW-1:0] occupancy;
  logic          req_vld;
  logic          req_acc;
  logic          rsp_drop;
  logic          rsp_take;
  logic          instr_pop;
  logic          unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Credit window counts everything that may still land in the FIFO, including
  // responses that will be dropped, so a push never finds the FIFO full.
  assign occupancy = SW'(count_q) + SW'(inflight_q) + SW'(drop_cnt_q);
  assign req_vld   = !rst && (occupancy < DEPTH_W);
  assign req_acc   = req_vld && imem_req_ready;
  assign rsp_drop  = imem_rsp_valid && (drop_cnt_q != '0);
  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_take  = imem_rsp_valid && (drop_cnt_q == '0) && (inflight_q != '0);
  assign instr_pop = (count_q != '0) && instr_ready;

  always_comb begin
    pc_d       = pc_q;
    count_d    = count_q;
    inflight_d = inflight_q;
    drop_cnt_d = drop_cnt_q;
    pa_mem_d   = pa_mem_q;
    pa_wr_d    = pa_wr_q;
    pa_rd_d    = pa_rd_q;
    if_mem_d   = if_mem_q;
    if_wr_d    = if_wr_q;
    if_rd_d    = if_rd_q;

    if (redirect_valid) begin
      // Everything owed by memory becomes stale, including a request accepted
      // this very cycle; a response arriving now is already accounted for.
      pc_d       = {redirect_pc[31:2], 2'b00};
      count_d    = '0;
      inflight_d = '0;
      drop_cnt_d = CW'(SW'(drop_cnt_q) + SW'(inflight_q) + SW'(req_acc)
                       - SW'(rsp_drop || rsp_take));
      pa_wr_d    = '0;
      pa_rd_d    = '0;
      if_wr_d    = '0;
      if_rd_d    = '0;
    end else begin
      if (req_acc) begin
        pa_mem_d[pa_wr_q] = pc_q;
        pa_wr_d           = pa_wr_q + AW'(1);
        pc_d              = pc_q + 32'd4;
      end
      if (rsp_drop) begin
        drop_cnt_d = drop_cnt_q - CW'(1);
      end
      if (rsp_take) begin
        if_mem_d[if_wr_q] = '{data: imem_rsp_data, pc: pa_mem_q[pa_rd_q]};
        if_wr_d           = if_wr_q + AW'(1);
        pa_rd_d           = pa_rd_q + AW'(1);
      end
      if (instr_pop) begin
        if_rd_d = if_rd_q + AW'(1);
      end
      inflight_d = inflight_q + CW'(req_acc) - CW'(rsp_take);
      count_d    = count_q + CW'(rsp_take) - CW'(instr_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC_W;
      count_q    <= '0;
      inflight_q <= '0;
      drop_cnt_q <= '0;
      pa_wr_q    <= '0;
      pa_rd_q    <= '0;
      if_wr_q    <= '0;
      if_rd_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      drop_cnt_q <= drop_cnt_d;
      pa_wr_q    <= pa_wr_d;
      pa_rd_q    <= pa_rd_d;
      if_wr_q    <= if_wr_d;
      if_rd_q    <= if_rd_d;
    end
  end

  // Storage needs no reset; pointers and counts define what is valid.
  always_ff @(posedge clk) begin
    pa_mem_q <= pa_mem_d;
    if_mem_q <= if_mem_d;
  end

  assign imem_req_valid = req_vld;
  assign imem_req_addr  = rst ? RESET_PC_W : pc_q;
  assign instr_valid    = !rst && (count_q != '0);
  assign instr          = rst ? 32'd0 : if_mem_q[if_rd_q].data;
  assign instr_pc       = rst ? 32'd0 : if_mem_q[if_rd_q].pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a randomized memory/decoder/redirect environment
// checked every cycle against a queue-based reference of the fetch rules.
module tb_instr_fetch;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = 32'd0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc    = 32'd0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready    = 1'b0;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Reference model: fetch state expressed as plain queues.
  logic [31:0] m_pc = RESET_PC;
  logic [31:0] m_pend[$];
  int          m_drop = 0;
  logic [31:0] m_fq_dat[$];
  logic [31:0] m_fq_pc[$];

  // Memory model: in-order, at least one cycle of latency.
  logic [31:0] mem_addr_q[$];
  int          mem_cyc_q[$];
  int          cyc = 0;

  // Environment knobs (percent probabilities).
  int p_req_rdy = 100, p_rsp = 100, p_irdy = 100, p_redir = 0, p_rst = 0;
  bit force_rst = 1'b1;
  bit redir_once = 1'b0;
  logic [31:0] redir_once_pc = 32'd0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0F1E_2D3C;
  endfunction

  function automatic logic [31:0] rand_target();
    case ($urandom_range(3))
      0:       return 32'h0000_0100;
      1:       return 32'hFFFF_FFF0 | 32'($urandom_range(15));
      2:       return $urandom;
      default: return 32'h0000_0203;
    endcase
  endfunction

  task automatic set_knobs(input int rr, input int rsp, input int irdy,
                           input int redir, input int rstp);
    p_req_rdy = rr; p_rsp = rsp; p_irdy = irdy; p_redir = redir; p_rst = rstp;
  endtask

  task automatic step();
    bit   ev_rv, ev_iv, acc, legit;
    logic [31:0] ev_addr, a;
    int   occ;
    @(negedge clk);
    rst = force_rst || ($urandom_range(99) < p_rst);
    #1;
    occ     = m_fq_dat.size() + m_pend.size() + m_drop;
    ev_rv   = !rst && (occ < DEPTH);
    ev_addr = rst ? RESET_PC : m_pc;
    ev_iv   = !rst && (m_fq_dat.size() != 0);
    chk("imem_req_valid", 32'(imem_req_valid), 32'(ev_rv));
    chk("imem_req_addr", imem_req_addr, ev_addr);
    chk("instr_valid", 32'(instr_valid), 32'(ev_iv));
    if (rst) begin
      chk("instr_in_reset", instr, 32'd0);
      chk("instr_pc_in_reset", instr_pc, 32'd0);
    end else if (ev_iv) begin
      chk("instr", instr, m_fq_dat[0]);
      chk("instr_pc", instr_pc, m_fq_pc[0]);
    end

    imem_req_ready = ($urandom_range(99) < p_req_rdy);
    if (mem_addr_q.size() != 0 && mem_cyc_q[0] < cyc && $urandom_range(99) < p_rsp) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_data(mem_addr_q.pop_front());
      void'(mem_cyc_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    if (redir_once) begin
      redirect_valid = 1'b1;
      redirect_pc    = redir_once_pc;
      redir_once     = 1'b0;
    end else begin
      redirect_valid = ($urandom_range(99) < p_redir);
      redirect_pc    = rand_target();
    end
    instr_ready = ($urandom_range(99) < p_irdy);

    acc = ev_rv && imem_req_ready;
    if (acc) begin
      mem_addr_q.push_back(m_pc);
      mem_cyc_q.push_back(cyc);
    end

    legit = imem_rsp_valid && (m_drop > 0 || m_pend.size() > 0);
    if (rst) begin
      m_pc = RESET_PC; m_drop = 0;
      m_pend.delete(); m_fq_dat.delete(); m_fq_pc.delete();
    end else if (redirect_valid) begin
      m_drop = m_drop + m_pend.size() + int'(acc) - int'(legit);
      m_pend.delete(); m_fq_dat.delete(); m_fq_pc.delete();
      m_pc = redirect_pc & 32'hFFFF_FFFC;
    end else begin
      if (ev_iv && instr_ready) begin
        void'(m_fq_dat.pop_front());
        void'(m_fq_pc.pop_front());
      end
      if (imem_rsp_valid) begin
        if (m_drop > 0) m_drop--;
        else if (m_pend.size() > 0) begin
          a = m_pend.pop_front();
          m_fq_dat.push_back(imem_rsp_data);
          m_fq_pc.push_back(a);
        end
      end
      if (acc) begin
        m_pend.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic redirect_now(input logic [31:0] target);
    redir_once    = 1'b1;
    redir_once_pc = target;
    step();
  endtask

  initial begin
    // Reset, then streaming with an ideal memory and decoder.
    force_rst = 1'b1;
    set_knobs(100, 100, 100, 0, 0);
    run(3);
    force_rst = 1'b0;
    run(30);
    // Decoder stall: credits run out, nothing lost on release.
    set_knobs(100, 100, 0, 0, 0);
    run(10);
    set_knobs(100, 100, 100, 0, 0);
    run(10);
    // Memory not accepting: address held.
    set_knobs(0, 100, 100, 0, 0);
    run(5);
    set_knobs(100, 100, 100, 0, 0);
    run(10);
    // Two requests outstanding, then redirect: both responses dropped.
    set_knobs(100, 0, 100, 0, 0);
    run(3);
    redirect_now(32'h0000_0100);
    set_knobs(100, 100, 100, 0, 0);
    run(10);
    // Misaligned redirect in steady state (same-cycle response/handshake).
    redirect_now(32'h0000_0203);
    run(10);
    // PC wrap through 0xFFFF_FFFC.
    redirect_now(32'hFFFF_FFF0);
    run(12);
    // Reset with requests outstanding; late responses arrive afterwards.
    set_knobs(100, 0, 100, 0, 0);
    run(3);
    force_rst = 1'b1;
    set_knobs(100, 100, 100, 0, 0);
    run(2);
    force_rst = 1'b0;
    run(10);
    // Randomized mix of everything.
    for (int blk = 0; blk < 20; blk++) begin
      set_knobs($urandom_range(20, 100), $urandom_range(20, 100),
                $urandom_range(0, 100), $urandom_range(0, 10), $urandom_range(0, 2));
      run(100);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
